multi_operand_adder: RTL and testbench
======================================

MULTI_OPERAND_ADDER -- requirements
Module: multi_operand_adder

Interface
REQ-001 Parameter N, default 4: number of pushbutton-loaded operand channels, range 1..16.
REQ-002 Parameter W, default 4: operand width in bits.
REQ-003 Parameter SW, default 7: sum width in bits; SW >= W SHALL hold.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 pb  input  N: per-channel load buttons, level signals synchronous to clk.
REQ-007 rpb  input  1: loads the extra operand and starts a summation.
REQ-008 y  input  W: shared operand data bus.
REQ-009 sum  output  SW: registered result, (sum of N channel operands + extra operand) mod 2^SW.
REQ-010 valid  output  1: one-cycle pulse marking a new sum.
REQ-011 busy  output  1: high while a summation is in progress.
REQ-012 overflow  output  1: high when the true sum of the last result is >= 2^SW.

Function
REQ-013 Each pb bit and rpb SHALL be edge-detected against its value registered on the previous cycle; a rising edge is prev=0 and cur=1.
REQ-014 A pb[i] rising edge while busy=0 SHALL load op[i] <= y at that clock edge; several simultaneous edges SHALL load y into every flagged channel.
REQ-015 A held-high pb or rpb SHALL cause only one load; a new load requires a fall and a new rise.
REQ-016 FSM states SHALL be IDLE and ACC; reset enters IDLE.
REQ-017 In IDLE, an rpb rising edge at edge k SHALL load ext <= y, clear acc to 0, set idx to 0, and enter ACC with busy=1 from edge k onward.
REQ-018 At each of edges k+1 .. k+N+1, ACC SHALL compute acc <= acc + operand[idx] and increment idx; operand[0..N-1] = op[0..N-1] and operand[N] = ext.
REQ-019 acc SHALL be SW+clog2(N+1) bits wide so no carry is lost.
REQ-020 At edge k+N+1, the following SHALL all happen:
- sum <= low SW bits of the final acc
- overflow <= 1 if any bit above SW-1 is set, else 0
- valid <= 1 for exactly one cycle
- FSM returns to IDLE and busy <= 0
REQ-021 Latency from the start edge to valid SHALL be N+1 cycles (5 at default parameters).
REQ-022 A pb[i] and rpb rising edge in the same IDLE cycle SHALL load op[i] and start; the newly loaded value SHALL be included in the sum.
REQ-023 While busy=1, pb and rpb edges SHALL be ignored: no operand changes and no restart. The edge detector's previous-value registers SHALL still track the inputs.
REQ-024 sum and overflow SHALL hold their last values until the next completion; valid SHALL be 0 on all other cycles.
REQ-025 Operands are unsigned, and y SHALL be zero-extended when added.

Reset
REQ-026 Asserting reset SHALL immediately set op[], ext, acc, idx, sum, overflow, valid, busy, and the edge-detector registers to 0, and the FSM to IDLE, regardless of the clock.
REQ-027 Reset asserted during ACC SHALL abort the summation with no valid pulse. The first rpb rising edge after deassertion SHALL start a clean summation.
REQ-028 An input already high when reset deasserts SHALL NOT count as a rising edge, because the previous-value registers reset to 0 but only after one sampled cycle.

Verification
REQ-029 Default parameters: pb[0]..pb[3] pulsed in turn with y=9, then rpb with y=9 -> valid exactly 5 cycles after the start edge; sum=45 (0101101); overflow=0.
REQ-030 All five operands 15 -> sum=75 (1001011), overflow=0; then all operands 0 -> sum=0, valid pulses again.
REQ-031 SW=6, all operands 15 -> sum=11 (001011), overflow=1.
REQ-032 pb[2] pulsed with y=3 and rpb pulsed again, both during busy -> result unchanged from the pre-start operands; exactly one valid pulse; op[2] unchanged.
REQ-033 Reset asserted 2 cycles into ACC -> busy, sum, and valid read 0 at once; a fresh load-and-start sequence then yields the correct sum.
REQ-034 pb[1] held high for 10 cycles while y changes 1 -> 7 -> op[1]=1, the value at the rising edge only; simultaneous pb[3]+rpb edge with y=4 -> op[3]=4 and ext=4, both included in the sum.

Source files
------------

// File: rtl/multi_operand_adder.sv
// multi_operand_adder
//   Sums N pushbutton-loaded operands plus one extra operand. The sum is
//   produced sequentially, one operand per clock.
//
//   Operand loading:
//     - A rising edge on pb[i] while idle loads op[i] from y.
//     - A rising edge on rpb while idle loads ext from y and starts a
//       summation.
//
//   Summation timing:
//     - The accumulator adds op[0..N-1] and then ext, one per clock.
//     - The result appears N+1 cycles after the start edge.
//     - Edges that arrive while busy are ignored.
//
//   Handshake: there is no back-pressure. valid is a single-cycle pulse.
//   sum and overflow are qualified by that pulse and hold their values
//   until the next completion.
//
//   Ports
//     clk       rising-edge clock
//     reset     asynchronous, active-high reset
//     pb[N]     per-channel load buttons (level, synchronous to clk)
//     rpb       loads the extra operand and starts a summation
//     y[W]      shared operand data bus
//     sum[SW]   registered result, modulo 2^SW
//     valid     one-cycle pulse marking a new sum
//     busy      high while a summation is in progress
//     overflow  high when the last true sum did not fit in SW bits
//     dbg_state current FSM state (0 = IDLE, 1 = ACC)
module multi_operand_adder #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int SW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  pb,
  input  logic          rpb,
  input  logic [W-1:0]  y,
  output logic [SW-1:0] sum,
  output logic          valid,
  output logic          busy,
  output logic          overflow,
  output logic          dbg_state
);

  localparam int IW = $clog2(N + 1);
  localparam int AW = SW + IW;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t         state, state_next;
  logic [W-1:0]   op [N];
  logic [W-1:0]   ext;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_next;
  logic [IW-1:0]  idx;
  logic [W-1:0]   sel;
  logic           last;

  // Edge detection.
  // armed stays low for the first sampled cycle after reset. An input
  // that is already high when reset releases therefore only primes the
  // previous-value register. It is not seen as a rising edge.
  logic [N-1:0]   pb_prev;
  logic           rpb_prev;
  logic           armed;
  logic [N-1:0]   pb_rise;
  logic           rpb_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_prev  <= '0;
      rpb_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      pb_prev  <= pb;
      rpb_prev <= rpb;
      armed    <= 1'b1;
    end
  end

  assign pb_rise  = armed ? (pb & ~pb_prev) : '0;
  assign rpb_rise = armed & rpb & ~rpb_prev;

  // Operand select: idx 0..N-1 picks a channel; idx N picks ext.
  always_comb begin
    sel = ext;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) sel = op[i];
    end
  end

  assign last     = (idx == IW'(N));
  assign acc_next = acc + AW'(sel);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rpb_rise) state_next = ACC;
      ACC:     if (last)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == ACC);
  assign dbg_state = state;

  // Datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) op[i] <= '0;
      ext      <= '0;
      acc      <= '0;
      idx      <= '0;
      sum      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        // A channel load and a start on the same edge are both taken.
        // The new channel value is read later, during ACC.
        for (int i = 0; i < N; i++) begin
          if (pb_rise[i]) op[i] <= y;
        end
        if (rpb_rise) begin
          ext <= y;
          acc <= '0;
          idx <= '0;
        end
      end else begin
        acc <= acc_next;
        idx <= idx + IW'(1);
        if (last) begin
          sum      <= acc_next[SW-1:0];
          overflow <= |acc_next[AW-1:SW];
          valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_operand_adder.sv
module tb_multi_operand_adder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pb;
  logic       rpb;
  logic [3:0] y;

  logic [6:0] sum7;
  logic       valid7, busy7, ovf7, dbg7;
  logic [5:0] sum6;
  logic       valid6, busy6, ovf6, dbg6;

  always #5 clk = ~clk;

  multi_operand_adder #(.N(4), .W(4), .SW(7)) dut (
    .clk(clk), .reset(reset), .pb(pb), .rpb(rpb), .y(y),
    .sum(sum7), .valid(valid7), .busy(busy7), .overflow(ovf7), .dbg_state(dbg7)
  );

  // Narrow-sum instance driven with the same stimulus.
  multi_operand_adder #(.N(4), .W(4), .SW(6)) dut6 (
    .clk(clk), .reset(reset), .pb(pb), .rpb(rpb), .y(y),
    .sum(sum6), .valid(valid6), .busy(busy6), .overflow(ovf6), .dbg_state(dbg6)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input int i, input logic [3:0] val);
    y = val;
    pb = '0;
    pb[i] = 1'b1;
    tick();
    pb = '0;
    tick();
  endtask

  // Start a summation with ext=val (pbmask raised on the same edge),
  // optionally inject pb[2]/rpb edges while busy, then watch a bounded
  // window of cycles.
  task automatic run_start(input string name, input logic [3:0] val, input logic [3:0] pbmask,
                           input bit inject, input int s7, input int o7, input int s6, input int o6);
    int nval;
    int lat;
    nval = 0;
    lat  = 0;
    y    = val;
    pb   = pbmask;
    rpb  = 1'b1;
    exp_q.push_back(7'(s7));
    @(posedge clk);
    #1;
    rpb = 1'b0;
    pb  = '0;
    check({name, "_busy_start"}, busy7, 1);
    for (int c = 1; c <= 12; c++) begin
      if (inject && c == 2) begin
        y = 4'd3; pb = 4'b0100; rpb = 1'b1;
      end
      if (inject && c == 3) begin
        pb = '0; rpb = 1'b0;
      end
      tick();
      if (valid7) begin
        nval++;
        if (lat == 0) lat = c;
        if (exp_q.size() > 0) check({name, "_sum7"}, sum7, exp_q.pop_front());
        check({name, "_ovf7"}, ovf7, o7);
        check({name, "_sum6"}, sum6, s6);
        check({name, "_ovf6"}, ovf6, o6);
      end
    end
    if (nval == 0) exp_q.delete();
    check({name, "_latency"}, lat, 5);
    check({name, "_valid_count"}, nval, 1);
    check({name, "_busy_end"}, busy7, 0);
    check({name, "_sum7_hold"}, sum7, s7);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] a, b, c, d, e;
    int s7, o7, s6, o6;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{a:9,  b:9,  c:9,  d:9,  e:9,  s7:45, o7:0, s6:45, o6:0};
    vecs[1] = '{a:15, b:15, c:15, d:15, e:15, s7:75, o7:0, s6:11, o6:1};
    vecs[2] = '{a:0,  b:0,  c:0,  d:0,  e:0,  s7:0,  o7:0, s6:0,  o6:0};
    vecs[3] = '{a:1,  b:2,  c:3,  d:4,  e:5,  s7:15, o7:0, s6:15, o6:0};
    vecs[4] = '{a:15, b:15, c:15, d:15, e:0,  s7:60, o7:0, s6:60, o6:0};
    vecs[5] = '{a:8,  b:0,  c:15, d:1,  e:7,  s7:31, o7:0, s6:31, o6:0};

    reset = 1'b1;
    pb = '0; rpb = 1'b0; y = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_sum", sum7, 0);
    check("rst_valid", valid7, 0);
    check("rst_busy", busy7, 0);
    check("rst_ovf", ovf7, 0);
    check("rst_state", dbg7, 0);
    tick();

    for (int v = 0; v < 6; v++) begin
      load_op(0, vecs[v].a);
      load_op(1, vecs[v].b);
      load_op(2, vecs[v].c);
      load_op(3, vecs[v].d);
      run_start($sformatf("vec%0d", v), vecs[v].e, 4'b0000, 1'b0,
                vecs[v].s7, vecs[v].o7, vecs[v].s6, vecs[v].o6);
    end

    // Edges during busy are ignored; op[2] must keep 6 afterwards.
    load_op(0, 4'd1);
    load_op(1, 4'd2);
    load_op(2, 4'd6);
    load_op(3, 4'd4);
    run_start("busy_inject", 4'd5, 4'b0000, 1'b1, 18, 0, 18, 0);
    tick();
    run_start("op2_kept", 4'd5, 4'b0000, 1'b0, 18, 0, 18, 0);

    // Reset two cycles into ACC aborts with no result.
    y = 4'd5; rpb = 1'b1;
    tick();
    rpb = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy7, 0);
    check("midrst_sum", sum7, 0);
    check("midrst_valid", valid7, 0);
    check("midrst_state", dbg7, 0);
    // Inputs already high when reset releases must not count as edges.
    pb = 4'b0001; rpb = 1'b1; y = 4'd11;
    @(posedge clk);
    #3 reset = 1'b0;
    tick(); tick(); tick();
    check("held_no_start", busy7, 0);
    check("held_no_valid", valid7, 0);
    pb = '0; rpb = 1'b0;
    tick();
    load_op(1, 4'd4);
    load_op(2, 4'd6);
    load_op(3, 4'd8);
    run_start("post_rst", 4'd10, 4'b0000, 1'b0, 28, 0, 28, 0);

    // pb[1] held high while y changes: only the rising-edge value loads.
    y = 4'd1; pb = 4'b0010;
    tick();
    y = 4'd7;
    repeat (9) tick();
    pb = '0;
    tick();
    // Simultaneous pb[3] + rpb: op = {0,1,6,4}, ext = 4.
    run_start("held_simul", 4'd4, 4'b1000, 1'b0, 15, 0, 15, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
